// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and default widths for the ALU scheduler.
package alu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RES_W  = 32;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_SHL     = 3'b011;
  localparam logic [2:0] OP_SHR     = 3'b100;
  localparam logic [2:0] OP_ASHL    = 3'b101;
  localparam logic [2:0] OP_ASHR    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only add and subtract report signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer register is owned by the parent.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = pointer ? 2'b10 : 2'b01;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/simpleALU.sv
// Combinational 16-bit signed ALU producing a 32-bit sign-extended result.
module simpleALU
  import alu_pkg::*;
(
  input  logic [2:0]            opcode,
  input  logic [DEF_DATA_W-1:0] a,
  input  logic [DEF_DATA_W-1:0] b,
  output logic [DEF_RES_W-1:0]  result,
  output logic                  is_ovf
);

  logic signed [DEF_RES_W-1:0] a_ext;
  logic signed [DEF_RES_W-1:0] b_ext;
  logic signed [DEF_RES_W-1:0] sum;
  logic signed [DEF_RES_W-1:0] diff;
  logic [DEF_DATA_W-1:0]       shift;

  assign a_ext = {{(DEF_RES_W-DEF_DATA_W){a[DEF_DATA_W-1]}}, a};
  assign b_ext = {{(DEF_RES_W-DEF_DATA_W){b[DEF_DATA_W-1]}}, b};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;

  // Overflow means the 17-bit true value does not fit back into 16 bits.
  always_comb begin
    result = '0;
    is_ovf = 1'b0;
    shift  = '0;
    case (opcode)
      OP_ADD: begin
        result = sum;
        is_ovf = sum[DEF_DATA_W] ^ sum[DEF_DATA_W-1];
      end
      OP_SUB: begin
        result = diff;
        is_ovf = diff[DEF_DATA_W] ^ diff[DEF_DATA_W-1];
      end
      OP_MUL: result = a_ext * b_ext;
      OP_SHL, OP_ASHL: begin
        shift  = a << b;
        result = {{(DEF_RES_W-DEF_DATA_W){shift[DEF_DATA_W-1]}}, shift};
      end
      OP_SHR: begin
        shift  = a >> b;
        result = {{(DEF_RES_W-DEF_DATA_W){shift[DEF_DATA_W-1]}}, shift};
      end
      OP_ASHR: begin
        shift  = $signed(a) >>> b;
        result = {{(DEF_RES_W-DEF_DATA_W){shift[DEF_DATA_W-1]}}, shift};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one simpleALU between two requesters with round-robin arbitration.
// Define ALU_OVF_CNT_EN to add the saturating ovf_count output.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RES_W      = DEF_RES_W,
  parameter bit PRIO_RESET = 1'b0
`ifdef ALU_OVF_CNT_EN
  ,parameter int CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_ovf,
  output logic              rsp_err
`ifdef ALU_OVF_CNT_EN
  ,output logic [CNT_W-1:0] ovf_count
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic              ptr_q;
  logic [1:0]        grant;
  logic              accept;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;
  logic [RES_W-1:0]  alu_result;
  logic              alu_ovf;
  logic              illegal;
  logic              ovf_next;

  rr_arb2 u_arb (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  // Ready is gated by rst_n so both stay low while reset is held.
  assign accept     = (state_q == ST_IDLE) && (grant != 2'b00);
  assign req0_ready = rst_n && (state_q == ST_IDLE) && grant[0];
  assign req1_ready = rst_n && (state_q == ST_IDLE) && grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The ALU only ever sees the latched command, never the live request ports.
  simpleALU u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .is_ovf (alu_ovf)
  );

  assign illegal  = (op_q == OP_ILLEGAL);
  assign ovf_next = alu_ovf && is_arith(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PRIO_RESET;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= grant[1] ? req1_opcode : req0_opcode;
        a_q   <= grant[1] ? req1_a : req0_a;
        b_q   <= grant[1] ? req1_b : req0_b;
        id_q  <= grant[1];
        ptr_q <= grant[0];
      end
      if (state_q == ST_EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_q;
        rsp_result <= illegal ? '0 : alu_result;
        rsp_ovf    <= ovf_next;
        rsp_err    <= illegal;
      end
      if ((state_q == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if ((state_q == ST_EXEC) && ovf_next && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios plus a randomized
// run against a behavioural arbitration/ALU model.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;
  logic [31:0] rsp_result;
`ifdef ALU_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic        rv  [2];
  logic [2:0]  rop [2];
  logic [15:0] ra  [2];
  logic [15:0] rb  [2];

  always #5 clk = ~clk;

  alu_rr_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_ovf     (rsp_ovf),
    .rsp_err     (rsp_err)
`ifdef ALU_OVF_CNT_EN
    ,.ovf_count  (ovf_count)
`endif
  );

  // Reference ALU computed from plain integer arithmetic on the operand values.
  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] res, output logic ovf, output logic err);
    longint sa, sb, ua, r, p2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    p2 = 1;
    for (int i = 0; i < 16 && i < int'(b); i++) p2 = p2 * 2;
    r = 0; ovf = 1'b0; err = 1'b0;
    case (op)
      3'd0: begin r = sa + sb; ovf = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; ovf = (r > 32767) || (r < -32768); end
      3'd2: r = sa * sb;
      3'd3, 3'd5: r = (b >= 16) ? 0 : (ua * p2) % 65536;
      3'd4: r = (b >= 16) ? 0 : ua / p2;
      3'd6: begin
        if (b >= 16) r = (sa < 0) ? -1 : 0;
        else if (sa >= 0) r = sa / p2;
        else r = -((-sa + p2 - 1) / p2);
      end
      default: err = 1'b1;
    endcase
    if ((op == 3'd3 || op == 3'd4 || op == 3'd5) && r >= 32768) r = r - 65536;
    res = r[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_opcode = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready0 got=%b exp=0", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready1 got=%b exp=0", req1_ready); end
    n_vec++; if ({rsp_valid, rsp_id, rsp_ovf, rsp_err} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_rsp_flags got=%b exp=0000", {rsp_valid, rsp_id, rsp_ovf, rsp_err}); end
    n_vec++; if (rsp_result !== 32'h0) begin n_err++; $display("[TB] FAIL reset_result got=%h exp=00000000", rsp_result); end
`ifdef ALU_OVF_CNT_EN
    n_vec++; if (ovf_count !== 16'h0) begin n_err++; $display("[TB] FAIL reset_ovf_count got=%0d exp=0", ovf_count); end
`endif
    do_reset;
  endtask

  task automatic test_single_add;
    req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 16'h7FFF; req0_b = 16'h0001; rsp_ready = 1'b0;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("[TB] FAIL add_ready got=%b exp=10", {req0_ready, req1_ready}); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_idle_valid got=%b exp=0", rsp_valid); end
    tick; req0_valid = 1'b0; #1;
    n_vec++; if ({req0_ready, rsp_valid} !== 2'b00) begin n_err++; $display("[TB] FAIL add_exec got=%b exp=00", {req0_ready, rsp_valid}); end
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id, rsp_ovf, rsp_err} !== 4'b1010) begin n_err++; $display("[TB] FAIL add_rsp_flags got=%b exp=1010", {rsp_valid, rsp_id, rsp_ovf, rsp_err}); end
    n_vec++; if (rsp_result !== 32'h0000_8000) begin n_err++; $display("[TB] FAIL add_result got=%h exp=00008000", rsp_result); end
    rsp_ready = 1'b1;
    tick; #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_rsp_drop got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_both_valid;
    do_reset;
    req0_valid = 1'b1; req0_opcode = 3'b010; req0_a = 16'd3; req0_b = 16'hFFFC;
    req1_valid = 1'b1; req1_opcode = 3'b001; req1_a = 16'd5; req1_b = 16'd7;
    rsp_ready = 1'b1;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("[TB] FAIL both_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    tick; req0_valid = 1'b0; #1;
    n_vec++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin n_err++; $display("[TB] FAIL both_exec got=%b exp=000", {req0_ready, req1_ready, rsp_valid}); end
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id, req1_ready} !== 3'b100) begin n_err++; $display("[TB] FAIL both_rsp0_flags got=%b exp=100", {rsp_valid, rsp_id, req1_ready}); end
    n_vec++; if (rsp_result !== 32'hFFFF_FFF4) begin n_err++; $display("[TB] FAIL both_rsp0_result got=%h exp=fffffff4", rsp_result); end
    tick; #1;
    n_vec++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin n_err++; $display("[TB] FAIL both_second_grant got=%b exp=001", {rsp_valid, req0_ready, req1_ready}); end
    tick; req1_valid = 1'b0; #1;
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id, rsp_ovf, rsp_err} !== 4'b1100) begin n_err++; $display("[TB] FAIL both_rsp1_flags got=%b exp=1100", {rsp_valid, rsp_id, rsp_ovf, rsp_err}); end
    n_vec++; if (rsp_result !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL both_rsp1_result got=%h exp=fffffffe", rsp_result); end
    tick; rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 16'h0010; req0_b = 16'h0020;
    req1_valid = 1'b1; req1_opcode = 3'b000; req1_a = 16'h0001; req1_b = 16'h0002;
    rsp_ready = 1'b0;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("[TB] FAIL bp_grant got=%b exp=10", {req0_ready, req1_ready}); end
    tick; req0_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if ({rsp_valid, rsp_id, req0_ready, req1_ready} !== 4'b1000) begin n_err++; $display("[TB] FAIL bp_hold_flags cyc=%0d got=%b exp=1000", i, {rsp_valid, rsp_id, req0_ready, req1_ready}); end
      n_vec++; if (rsp_result !== 32'h0000_0030) begin n_err++; $display("[TB] FAIL bp_hold_result cyc=%0d got=%h exp=00000030", i, rsp_result); end
      tick;
    end
    rsp_ready = 1'b1;
    tick; #1;
    n_vec++; if ({rsp_valid, req1_ready} !== 2'b01) begin n_err++; $display("[TB] FAIL bp_idle_regained got=%b exp=01", {rsp_valid, req1_ready}); end
    tick; req1_valid = 1'b0;
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id} !== 2'b11 || rsp_result !== 32'h3) begin n_err++; $display("[TB] FAIL bp_req1_rsp got=%b/%h exp=11/00000003", {rsp_valid, rsp_id}, rsp_result); end
    tick; rsp_ready = 1'b0;
  endtask

  task automatic test_illegal;
    req1_valid = 1'b1; req1_opcode = 3'b111; req1_a = 16'h1234; req1_b = 16'h0001; rsp_ready = 1'b1;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("[TB] FAIL illegal_grant got=%b exp=01", {req0_ready, req1_ready}); end
    tick; req1_valid = 1'b0;
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id, rsp_ovf, rsp_err} !== 4'b1101) begin n_err++; $display("[TB] FAIL illegal_flags got=%b exp=1101", {rsp_valid, rsp_id, rsp_ovf, rsp_err}); end
    n_vec++; if (rsp_result !== 32'h0) begin n_err++; $display("[TB] FAIL illegal_result got=%h exp=00000000", rsp_result); end
    tick; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    req1_valid = 1'b1; req1_opcode = 3'b000; req1_a = 16'h7FFF; req1_b = 16'h0001; rsp_ready = 1'b1;
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_exec_grant got=%b exp=1", req1_ready); end
    tick; req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({rsp_valid, rsp_id, rsp_ovf, rsp_err, req0_ready, req1_ready} !== 6'b0) begin n_err++; $display("[TB] FAIL rst_exec_outputs got=%b exp=000000", {rsp_valid, rsp_id, rsp_ovf, rsp_err, req0_ready, req1_ready}); end
    n_vec++; if (rsp_result !== 32'h0) begin n_err++; $display("[TB] FAIL rst_exec_result got=%h exp=00000000", rsp_result); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_exec_no_rsp cyc=%0d got=%b exp=0", i, rsp_valid); end
    end
    req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_opcode = 3'b000; req1_a = 16'd2; req1_b = 16'd2;
    rsp_ready = 1'b0;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("[TB] FAIL rst_exec_ptr got=%b exp=10", {req0_ready, req1_ready}); end
    tick; req0_valid = 1'b0;
    tick; #1;
    n_vec++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_result !== 32'h2) begin n_err++; $display("[TB] FAIL rst_exec_next_rsp got=%b/%h exp=10/00000002", {rsp_valid, rsp_id}, rsp_result); end
  endtask

`ifdef ALU_OVF_CNT_EN
  task automatic test_ovf_count;
    logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b000};
    logic [15:0] as  [3] = '{16'h7FFF, 16'h8000, 16'd2};
    logic [15:0] bs  [3] = '{16'h0001, 16'h0001, 16'd3};
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_opcode = ops[i]; req0_a = as[i]; req0_b = bs[i];
      tick; req0_valid = 1'b0;
      tick; tick;
      if (i == 0) begin
        n_vec++; if (ovf_count !== 16'd1) begin n_err++; $display("[TB] FAIL ovf_count_first got=%0d exp=1", ovf_count); end
      end
    end
    n_vec++; if (ovf_count !== 16'd2) begin n_err++; $display("[TB] FAIL ovf_count_total got=%0d exp=2", ovf_count); end
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic drive_random;
    req0_valid = rv[0]; req0_opcode = rop[0]; req0_a = ra[0]; req0_b = rb[0];
    req1_valid = rv[1]; req1_opcode = rop[1]; req1_a = ra[1]; req1_b = rb[1];
  endtask

  task automatic test_random(input int ncyc);
    logic        held [2];
    logic        busy;
    int          age, mptr, g;
    logic [31:0] e_res;
    logic        e_ovf, e_err, e_id;
    do_reset;
    busy = 1'b0; age = 0; mptr = 0;
    e_res = '0; e_ovf = 1'b0; e_err = 1'b0; e_id = 1'b0;
    for (int r = 0; r < 2; r++) begin
      held[r] = 1'b0; rv[r] = 1'b0; rop[r] = '0; ra[r] = '0; rb[r] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++) begin
        if (held[r]) begin
          if ($urandom_range(0, 4) == 0) rv[r] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rv[r]  = 1'b1;
          rop[r] = 3'($urandom_range(0, 7));
          ra[r]  = 16'($urandom);
          rb[r]  = (rop[r] inside {3'd3, 3'd4, 3'd5, 3'd6}) ? 16'($urandom_range(0, 18)) : 16'($urandom);
        end else begin
          rv[r] = 1'b0;
        end
      end
      drive_random;
      #1;
      g = -1;
      if (!busy) begin
        if (rv[0] && rv[1]) g = mptr;
        else if (rv[0]) g = 0;
        else if (rv[1]) g = 1;
      end
      n_vec++; if (req0_ready !== (g == 0)) begin n_err++; $display("[TB] FAIL rnd_ready0 cyc=%0d got=%b exp=%b", c, req0_ready, (g == 0)); end
      n_vec++; if (req1_ready !== (g == 1)) begin n_err++; $display("[TB] FAIL rnd_ready1 cyc=%0d got=%b exp=%b", c, req1_ready, (g == 1)); end
      n_vec++; if (rsp_valid !== (busy && age >= 1)) begin n_err++; $display("[TB] FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, (busy && age >= 1)); end
      if (busy && age >= 1) begin
        n_vec++;
        if (rsp_id !== e_id || rsp_result !== e_res || rsp_ovf !== e_ovf || rsp_err !== e_err) begin
          n_err++;
          $display("[TB] FAIL rnd_rsp cyc=%0d got id=%b res=%h ovf=%b err=%b exp id=%b res=%h ovf=%b err=%b",
                   c, rsp_id, rsp_result, rsp_ovf, rsp_err, e_id, e_res, e_ovf, e_err);
        end
      end
      if (busy && age >= 1 && rsp_ready) busy = 1'b0;
      else if (busy) age++;
      if (g >= 0) begin
        ref_alu(rop[g], ra[g], rb[g], e_res, e_ovf, e_err);
        e_id = (g == 1);
        busy = 1'b1; age = 0; mptr = 1 - g;
      end
      for (int r = 0; r < 2; r++) held[r] = rv[r] && (g != r);
      @(posedge clk);
      #1;
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
    drive_random;
    rsp_ready = 1'b1;
    repeat (4) tick;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting alu_rr_scheduler bench");
    test_reset;
    test_single_add;
    test_both_valid;
    test_back_to_back;
    test_illegal;
    test_reset_mid_exec;
`ifdef ALU_OVF_CNT_EN
    test_ovf_count;
`endif
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
